multich_ringbuf: RTL and testbench

MULTICH_RINGBUF -- requirements
Module: multich_ringbuf

---
 rtl/multich_ringbuf.sv | 125 ++++++++++++
 tb/tb_multich_ringbuf.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multich_ringbuf.sv
// Multi-channel ring buffer: each channel requests samples upstream, queues them,
// and exposes a random-access read port relative to its oldest sample.
module multich_ringbuf #(
  parameter int NUM_CH      = 2,
  parameter int NUM_CH_LOG2 = 1,
  parameter int WIDTH       = 24,
  parameter int DEPTH_LOG2  = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CH-1:0]                  rst_ch,
  output logic [NUM_CH-1:0]                  pop_o,
  input  logic [NUM_CH-1:0]                  ack_i,
  input  logic [WIDTH*NUM_CH-1:0]            data_i,
  input  logic [NUM_CH-1:0]                  consume_i,
  input  logic                               rd_en,
  input  logic [NUM_CH_LOG2-1:0]             rd_ch,
  input  logic [DEPTH_LOG2-1:0]              rd_offset,
  output logic                               rd_valid,
  output logic [WIDTH-1:0]                   rd_data,
  output logic                               rd_err,
  output logic [(DEPTH_LOG2+1)*NUM_CH-1:0]   fill_o,
  output logic [NUM_CH-1:0]                  overrun_o,
  output logic [NUM_CH-1:0]                  underrun_o,
  input  logic                               clr_flags_i
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic {IDLE, WAIT} state_t;

  logic [NUM_CH-1:0][CW-1:0]    count;
  logic [NUM_CH-1:0][WIDTH-1:0] peek;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [WIDTH-1:0]      bank [DEPTH];
    state_t                state, state_nxt;
    logic                  pop_nxt, cons_ok, wr_ok, pop, ovr, und;
    logic [DEPTH_LOG2-1:0] wp, rp, ra;
    logic [CW-1:0]         cnt;

    assign cons_ok = consume_i[g] && (cnt != '0);
    // A full channel still accepts a write when a consume frees a slot this cycle.
    assign wr_ok   = ack_i[g] && ((cnt != CW'(DEPTH)) || cons_ok);
    assign ra      = rp + rd_offset;
    assign peek[g] = bank[ra];
    assign count[g]      = cnt;
    assign pop_o[g]      = pop;
    assign overrun_o[g]  = ovr;
    assign underrun_o[g] = und;
    assign fill_o[CW*g +: CW] = cnt;

    always_comb begin
      state_nxt = state;
      pop_nxt   = 1'b0;
      case (state)
        IDLE: if ((cnt + CW'(1)) < CW'(DEPTH)) begin
          pop_nxt   = 1'b1;
          state_nxt = WAIT;
        end
        WAIT: if (ack_i[g]) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
      if (rst_ch[g]) begin
        state_nxt = IDLE;
        pop_nxt   = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        pop   <= 1'b0;
        wp    <= '0;
        rp    <= '0;
        cnt   <= '0;
        ovr   <= 1'b0;
        und   <= 1'b0;
      end else begin
        state <= state_nxt;
        pop   <= pop_nxt;
        if (rst_ch[g]) begin
          wp  <= '0;
          rp  <= '0;
          cnt <= '0;
          ovr <= 1'b0;
          und <= 1'b0;
        end else begin
          if (wr_ok)   wp <= wp + 1'b1;
          if (cons_ok) rp <= rp + 1'b1;
          cnt <= cnt + CW'(wr_ok) - CW'(cons_ok);
          // Setting beats clearing so an error in the clear cycle is not lost.
          if (ack_i[g] && !wr_ok)          ovr <= 1'b1;
          else if (clr_flags_i)            ovr <= 1'b0;
          if (consume_i[g] && !cons_ok)    und <= 1'b1;
          else if (clr_flags_i)            und <= 1'b0;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (wr_ok && !rst_ch[g] && !rst) bank[wp] <= data_i[WIDTH*g +: WIDTH];
    end
  end

  logic                   ch_bad, miss;
  logic [NUM_CH_LOG2-1:0] ch_sel;

  assign ch_bad = int'(rd_ch) >= NUM_CH;
  assign ch_sel = ch_bad ? '0 : rd_ch;
  // Occupancy is the pre-update count, so offset 0 is the oldest sample before this cycle's consume.
  assign miss   = ch_bad || ({1'b0, rd_offset} >= count[ch_sel]) || rst_ch[ch_sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en && miss;
      rd_data  <= (rd_en && !miss) ? peek[ch_sel] : '0;
    end
  end
endmodule

// File: tb/tb_multich_ringbuf.sv
// Directed bench for multich_ringbuf: table-driven reads plus hand sequences for
// full/empty, wrap, channel reset and async reset corner cases.
module tb_multich_ringbuf;
  localparam int NC = 2, NCL = 1, W = 24, DL = 5, CW = 6;

  logic              clk = 1'b0, rst;
  logic [NC-1:0]     rst_ch, pop_o, ack_i, consume_i, overrun_o, underrun_o;
  logic [W*NC-1:0]   data_i;
  logic              rd_en, rd_valid, rd_err, clr_flags_i;
  logic [NCL-1:0]    rd_ch;
  logic [DL-1:0]     rd_offset;
  logic [W-1:0]      rd_data;
  logic [CW*NC-1:0]  fill_o;

  always #5 clk = ~clk;

  multich_ringbuf #(.NUM_CH(NC), .NUM_CH_LOG2(NCL), .WIDTH(W), .DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst(rst), .rst_ch(rst_ch), .pop_o(pop_o), .ack_i(ack_i),
    .data_i(data_i), .consume_i(consume_i), .rd_en(rd_en), .rd_ch(rd_ch),
    .rd_offset(rd_offset), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .fill_o(fill_o), .overrun_o(overrun_o), .underrun_o(underrun_o),
    .clr_flags_i(clr_flags_i)
  );

  typedef struct {
    logic [NCL-1:0] ch;
    logic [DL-1:0]  off;
    logic           err;
    logic [W-1:0]   data;
  } rd_vec_t;

  rd_vec_t vecs [6];
  int total = 0, bad = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] fill(input int ch);
    return fill_o[CW*ch +: CW];
  endfunction

  // Wait briefly for a request, then deliver one sample either way.
  task automatic push(input int ch, input logic [W-1:0] d, output bit saw);
    saw = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (pop_o[ch]) begin saw = 1'b1; break; end
      step();
    end
    ack_i[ch] = 1'b1;
    data_i[W*ch +: W] = d;
    step();
    ack_i[ch] = 1'b0;
  endtask

  task automatic rd(input int ch, input int off);
    rd_en = 1'b1; rd_ch = NCL'(ch); rd_offset = DL'(off);
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit saw, seen;
    vecs[0] = '{ch: 1'd0, off: 5'd0,  err: 1'b0, data: 24'd1};
    vecs[1] = '{ch: 1'd0, off: 5'd1,  err: 1'b0, data: 24'd2};
    vecs[2] = '{ch: 1'd0, off: 5'd2,  err: 1'b0, data: 24'd3};
    vecs[3] = '{ch: 1'd0, off: 5'd3,  err: 1'b1, data: 24'd0};
    vecs[4] = '{ch: 1'd1, off: 5'd0,  err: 1'b1, data: 24'd0};
    vecs[5] = '{ch: 1'd0, off: 5'd31, err: 1'b1, data: 24'd0};

    rst = 1'b1; rst_ch = '0; ack_i = '0; consume_i = '0; data_i = '0;
    rd_en = 1'b0; rd_ch = '0; rd_offset = '0; clr_flags_i = 1'b0;
    step(); step();
    chk("rst_pop", pop_o, 0);
    chk("rst_fill", fill_o, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_flags", {overrun_o, underrun_o}, 0);
    rst = 1'b0;
    step();
    chk("pop_after_rst", pop_o, 2'b11);

    // Basic fill and table-driven reads
    for (int v = 1; v <= 3; v++) begin
      push(0, W'(v), saw);
      chk("pop_seen", saw, 1);
    end
    chk("fill0_3", fill(0), 3);
    for (int i = 0; i < 6; i++) begin
      rd(vecs[i].ch, vecs[i].off);
      chk("vec_valid", rd_valid, 1);
      chk("vec_err", rd_err, vecs[i].err);
      chk("vec_data", rd_data, vecs[i].data);
    end
    step();
    chk("idle_rd_valid", rd_valid, 0);
    chk("idle_rd_data", rd_data, 0);

    // ch1 fill to 31, no more requests, unsolicited to 32, then overrun
    for (int i = 0; i < 40 && fill(1) < 31; i++) push(1, W'(100 + i), saw);
    chk("fill1_31", fill(1), 31);
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin seen |= pop_o[1]; step(); end
    chk("no_pop_at_31", seen, 0);
    push(1, 24'd200, saw);
    chk("fill1_32", fill(1), 32);
    chk("no_overrun_32", overrun_o[1], 0);
    push(1, 24'd201, saw);
    chk("overrun1", overrun_o[1], 1);
    chk("fill1_still_32", fill(1), 32);
    rd(1, 31);
    chk("ch1_last_data", rd_data, 200);
    rd(1, 0);
    chk("ch1_first_data", rd_data, 100);
    clr_flags_i = 1'b1; step(); clr_flags_i = 1'b0;
    chk("overrun_clr", overrun_o[1], 0);

    // Underrun and set-beats-clear
    consume_i[0] = 1'b1;
    step(); step(); step();
    chk("fill0_drained", fill(0), 0);
    chk("no_underrun_yet", underrun_o[0], 0);
    step();
    consume_i[0] = 1'b0;
    chk("underrun0", underrun_o[0], 1);
    chk("fill0_stays_0", fill(0), 0);
    clr_flags_i = 1'b1; step(); clr_flags_i = 1'b0;
    chk("underrun_clr", underrun_o[0], 0);
    consume_i[0] = 1'b1; clr_flags_i = 1'b1; step();
    consume_i[0] = 1'b0; clr_flags_i = 1'b0;
    chk("set_beats_clr", underrun_o[0], 1);
    clr_flags_i = 1'b1; step(); clr_flags_i = 1'b0;
    chk("underrun_clr2", underrun_o[0], 0);

    // Pointer wrap: write, then read offset 0 while consuming in the same cycle
    for (int i = 0; i < 40; i++) begin
      push(0, W'(500 + i), saw);
      rd_en = 1'b1; rd_ch = '0; rd_offset = '0; consume_i[0] = 1'b1;
      step();
      rd_en = 1'b0; consume_i[0] = 1'b0;
      chk("wrap_data", rd_data, 500 + i);
      chk("wrap_err", rd_err, 0);
    end
    chk("wrap_fill0", fill(0), 0);

    // Full channel: simultaneous write and consume
    for (int i = 0; i < 40 && fill(0) < 31; i++) push(0, W'(700 + fill(0)), saw);
    push(0, 24'd731, saw);
    chk("fill0_32", fill(0), 32);
    ack_i[0] = 1'b1; data_i[W-1:0] = 24'd999; consume_i[0] = 1'b1;
    step();
    ack_i[0] = 1'b0; consume_i[0] = 1'b0;
    chk("full_wc_fill", fill(0), 32);
    chk("full_wc_no_overrun", overrun_o[0], 0);
    rd(0, 0);
    chk("full_wc_oldest", rd_data, 701);
    rd(0, 31);
    chk("full_wc_newest", rd_data, 999);

    // Channel reset while both channels wait
    consume_i = 2'b11; step(); step(); consume_i = '0;
    for (int n = 0; n < 5 && pop_o != 2'b11; n++) step();
    chk("both_wait", pop_o, 2'b11);
    rst_ch = 2'b01; ack_i = 2'b01; data_i[W-1:0] = 24'd55;
    rd_en = 1'b1; rd_ch = '0; rd_offset = '0;
    step();
    rst_ch = '0; ack_i = '0; rd_en = 1'b0;
    chk("rstch_rd_valid", rd_valid, 1);
    chk("rstch_rd_err", rd_err, 1);
    chk("rstch_rd_data", rd_data, 0);
    chk("rstch_fill0", fill(0), 0);
    chk("rstch_fill1", fill(1), 30);
    step();
    chk("rstch_pop0", pop_o[0], 1);
    seen = pop_o[1];
    for (int n = 0; n < 4; n++) begin step(); seen |= pop_o[1]; end
    chk("rstch_ch1_wait", seen, 0);
    rd(0, 0);
    chk("rstch_rd0_err", rd_err, 1);

    // Async reset drops a pending response immediately
    rd(0, 0);
    chk("pre_rst_valid", rd_valid, 1);
    rst = 1'b1; #1;
    chk("async_rst_valid", rd_valid, 0);
    chk("async_rst_pop", pop_o, 0);
    chk("async_rst_fill", fill_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
